// File: rtl/cv32e40x_aes_masked_unit.sv
// Masked AES32 unit: two-share datapath, byte-issue FSM, in-order tracking FIFO, credit-limited output FIFO, kill/flush.
// Define CV32E40X_AES_SUBWORD_EN to enable the four-pass subword operation (op 100); otherwise op 100 is reserved.
module cv32e40x_aes_masked_unit #(
    parameter int X_ID_WIDTH = 4,
    parameter int OUT_DEPTH  = 2,
    parameter int RAND_W     = 26
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [31:0]           rs1_i,
    input  logic [31:0]           rs2_i,
    input  logic [1:0]            bs_i,
    input  logic [2:0]            op_i,
    input  logic [RAND_W-1:0]     randombits_i,
    input  logic [X_ID_WIDTH-1:0] instr_id_i,
    input  logic                  kill_i,
    output logic [31:0]           result_o,
    output logic [X_ID_WIDTH-1:0] instr_id_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  sbox_valid_o,
    input  logic                  sbox_ready_i,
    output logic [7:0]            sbox_a_o,
    output logic [7:0]            sbox_b_o,
    output logic [RAND_W-9:0]     sbox_rand_o,
    output logic                  sbox_dec_o,
    input  logic                  sbox_valid_i,
    input  logic [7:0]            sbox_a_i,
    input  logic [7:0]            sbox_b_i
);
    localparam int AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CW = $clog2(OUT_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    typedef struct packed {
        logic [2:0]            op;
        logic [1:0]            bs;
        logic [31:0]           rs1;
        logic [X_ID_WIDTH-1:0] id;
    } trk_t;

    typedef struct packed {
        logic [31:0]           res;
        logic [X_ID_WIDTH-1:0] id;
    } out_t;

    function automatic logic [7:0] xt(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [2:0] npass(input logic [2:0] op);
`ifdef CV32E40X_AES_SUBWORD_EN
        if (op == 3'b100) return 3'd4;
`endif
        return op[2] ? 3'd0 : 3'd1;
    endfunction

    // Linear in x, so it is applied to each share independently.
    function automatic logic [31:0] contrib(input logic [2:0] op, input logic [1:0] rot, input logic [7:0] x);
        logic [7:0]  x2, x4, x8;
        logic [31:0] w;
        x2 = xt(x);
        x4 = xt(x2);
        x8 = xt(x4);
        case (op)
            3'b001:  w = {x2 ^ x, x, x, x2};
            3'b011:  w = {x8 ^ x2 ^ x, x8 ^ x4 ^ x, x8 ^ x, x8 ^ x4 ^ x2};
            default: w = {24'b0, x};
        endcase
        return (w << (8 * rot)) | (w >> (32 - 8 * rot));
    endfunction

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    state_t            state;
    logic [31:0]       rs2_q;
    logic [2:0]        op_q;
    logic [1:0]        bs_q;
    logic              hold;
    logic [7:0]        mask_q;
    logic [RAND_W-9:0] rand_q;
    logic [7:0]        pend;
    logic [CW-1:0]     cnt;
`ifdef CV32E40X_AES_SUBWORD_EN
    logic [1:0]        k_q;
`endif

    trk_t          trk_mem [OUT_DEPTH];
    logic [AW-1:0] trk_rd, trk_wr;
    logic [CW-1:0] trk_cnt;
    out_t          out_mem [OUT_DEPTH];
    logic [AW-1:0] out_rd, out_wr;
    logic [CW-1:0] out_cnt;
    logic [31:0]   acc_a, acc_b;
    logic [1:0]    r_idx;

    logic              accept, pop, sbox_hs, resp_live, trk_vld, head_done;
    logic [1:0]        cur_k, head_rot;
    logic [7:0]        mask;
    logic [RAND_W-9:0] rand_cur;
    logic [7:0]        pend_nxt;
    logic [2:0]        head_need;
    logic [31:0]       ca, cb, fin;
    trk_t              head;

    assign ready_o  = (state == IDLE) && (cnt < CW'(OUT_DEPTH)) && !kill_i;
    assign accept   = valid_i && ready_o;
    assign valid_o  = out_cnt != '0;
    assign pop      = valid_o && ready_i;
    assign result_o   = valid_o ? out_mem[out_rd].res : '0;
    assign instr_id_o = valid_o ? out_mem[out_rd].id : '0;

`ifdef CV32E40X_AES_SUBWORD_EN
    assign cur_k = (op_q == 3'b100) ? k_q : bs_q;
`else
    assign cur_k = bs_q;
`endif

    // While stalled the request replays the captured randomness so the payload stays stable.
    assign mask         = hold ? mask_q : randombits_i[7:0];
    assign rand_cur     = hold ? rand_q : randombits_i[RAND_W-1:8];
    assign sbox_valid_o = state == ISSUE;
    assign sbox_a_o     = sbox_valid_o ? (rs2_q[8*cur_k +: 8] ^ mask) : '0;
    assign sbox_b_o     = sbox_valid_o ? mask : '0;
    assign sbox_rand_o  = sbox_valid_o ? rand_cur : '0;
    assign sbox_dec_o   = sbox_valid_o && op_q[1];
    assign sbox_hs      = sbox_valid_o && sbox_ready_i;
    assign pend_nxt     = pend + 8'(sbox_hs) - 8'(sbox_valid_i);

    assign head      = trk_mem[trk_rd];
    assign trk_vld   = trk_cnt != '0;
    assign head_need = npass(head.op);
    assign head_rot  = (head.op == 3'b100) ? r_idx : head.bs;
    assign resp_live = sbox_valid_i && (state != DRAIN) && trk_vld;
    assign ca        = resp_live ? contrib(head.op, head_rot, sbox_a_i) : '0;
    assign cb        = resp_live ? contrib(head.op, head_rot, sbox_b_i) : '0;
    assign head_done = trk_vld && !kill_i &&
                       ((head_need == 3'd0) || (resp_live && ({1'b0, r_idx} == head_need - 3'd1)));
    assign fin       = head.rs1 ^ ((acc_a ^ ca) ^ (acc_b ^ cb));

    always_ff @(posedge clk_i) begin
        if (accept) trk_mem[trk_wr] <= '{op: op_i, bs: bs_i, rs1: rs1_i, id: instr_id_i};
        if (head_done) out_mem[out_wr] <= '{res: fin, id: head.id};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            rs2_q   <= '0;
            op_q    <= '0;
            bs_q    <= '0;
            hold    <= 1'b0;
            mask_q  <= '0;
            rand_q  <= '0;
            pend    <= '0;
            cnt     <= '0;
            trk_rd  <= '0;
            trk_wr  <= '0;
            trk_cnt <= '0;
            out_rd  <= '0;
            out_wr  <= '0;
            out_cnt <= '0;
            acc_a   <= '0;
            acc_b   <= '0;
            r_idx   <= '0;
`ifdef CV32E40X_AES_SUBWORD_EN
            k_q     <= '0;
`endif
        end else begin
            pend <= pend_nxt;
            if (kill_i) begin
                state   <= DRAIN;
                hold    <= 1'b0;
                cnt     <= '0;
                trk_rd  <= '0;
                trk_wr  <= '0;
                trk_cnt <= '0;
                out_rd  <= '0;
                out_wr  <= '0;
                out_cnt <= '0;
                acc_a   <= '0;
                acc_b   <= '0;
                r_idx   <= '0;
            end else begin
                case (state)
                    IDLE: if (accept) begin
                        rs2_q <= rs2_i;
                        op_q  <= op_i;
                        bs_q  <= bs_i;
                        hold  <= 1'b0;
`ifdef CV32E40X_AES_SUBWORD_EN
                        k_q   <= '0;
`endif
                        if (npass(op_i) != 3'd0) state <= ISSUE;
                    end
                    ISSUE: begin
                        hold   <= !sbox_ready_i;
                        mask_q <= mask;
                        rand_q <= rand_cur;
                        if (sbox_ready_i) begin
`ifdef CV32E40X_AES_SUBWORD_EN
                            if (op_q == 3'b100 && k_q != 2'd3) k_q <= k_q + 2'd1;
                            else state <= IDLE;
`else
                            state <= IDLE;
`endif
                        end
                    end
                    DRAIN: if (pend_nxt == '0) state <= IDLE;
                    default: state <= IDLE;
                endcase

                if (accept) trk_wr <= inc(trk_wr);
                trk_cnt <= trk_cnt + CW'(accept) - CW'(head_done);
                if (head_done) begin
                    trk_rd <= inc(trk_rd);
                    out_wr <= inc(out_wr);
                    acc_a  <= '0;
                    acc_b  <= '0;
                    r_idx  <= '0;
                end else if (resp_live) begin
                    acc_a <= acc_a ^ ca;
                    acc_b <= acc_b ^ cb;
                    r_idx <= r_idx + 2'd1;
                end
                if (pop) out_rd <= inc(out_rd);
                out_cnt <= out_cnt + CW'(head_done) - CW'(pop);
                cnt     <= cnt + CW'(accept) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_cv32e40x_aes_masked_unit.sv
// Directed and randomised checks of cv32e40x_aes_masked_unit against a behavioural masked-sbox child and an unmasked model.
module tb_cv32e40x_aes_masked_unit;
    localparam int XW = 4;
    localparam int RW = 26;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [31:0]   rs1_i = '0, rs2_i = '0;
    logic [1:0]    bs_i = '0;
    logic [2:0]    op_i = '0;
    logic [RW-1:0] randombits_i = '0;
    logic [XW-1:0] instr_id_i = '0;
    logic          kill_i = 1'b0;
    logic [31:0]   result_o;
    logic [XW-1:0] instr_id_o;
    logic          valid_o;
    logic          ready_i = 1'b1;
    logic          sbox_valid_o;
    logic          sbox_ready_i = 1'b1;
    logic [7:0]    sbox_a_o, sbox_b_o;
    logic [RW-9:0] sbox_rand_o;
    logic          sbox_dec_o;
    logic          sbox_valid_i = 1'b0;
    logic [7:0]    sbox_a_i = '0, sbox_b_i = '0;

    cv32e40x_aes_masked_unit #(.X_ID_WIDTH(XW), .OUT_DEPTH(2), .RAND_W(RW)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .bs_i(bs_i), .op_i(op_i),
        .randombits_i(randombits_i), .instr_id_i(instr_id_i), .kill_i(kill_i),
        .result_o(result_o), .instr_id_o(instr_id_o), .valid_o(valid_o), .ready_i(ready_i),
        .sbox_valid_o(sbox_valid_o), .sbox_ready_i(sbox_ready_i), .sbox_a_o(sbox_a_o),
        .sbox_b_o(sbox_b_o), .sbox_rand_o(sbox_rand_o), .sbox_dec_o(sbox_dec_o),
        .sbox_valid_i(sbox_valid_i), .sbox_a_i(sbox_a_i), .sbox_b_i(sbox_b_i)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [7:0] sb_t [256];
    logic [7:0] isb_t [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 0; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rol8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] rs1,
                                               input logic [31:0] rs2, input logic [1:0] bs);
        logic [7:0]  b, s, si;
        logic [31:0] w;
        b  = rs2[8*bs +: 8];
        s  = sb_t[b];
        si = isb_t[b];
        case (op)
            3'd0: w = {24'h0, s};
            3'd1: w = {gmul(s, 8'h03), s, s, gmul(s, 8'h02)};
            3'd2: w = {24'h0, si};
            3'd3: w = {gmul(si, 8'h0b), gmul(si, 8'h0d), gmul(si, 8'h09), gmul(si, 8'h0e)};
`ifdef CV32E40X_AES_SUBWORD_EN
            3'd4: return rs1 ^ {sb_t[rs2[31:24]], sb_t[rs2[23:16]], sb_t[rs2[15:8]], sb_t[rs2[7:0]]};
`endif
            default: return rs1;
        endcase
        return rs1 ^ ((w << (8 * bs)) | (w >> (32 - 8 * bs)));
    endfunction

    // Behavioural masked sbox child: fixed latency L, responses in order, remasked output.
    typedef struct { int due; logic [7:0] a; logic [7:0] b; } rsp_t;
    typedef struct { logic [31:0] res; logic [XW-1:0] id; } exp_t;
    rsp_t rsq[$];
    exp_t sbq[$];
    logic [7:0] masks[$];
    int L = 3;
    int cyc = 0;
    int hs_cnt = 0;
    int rdy_mode = 1;
    bit stall_en = 1'b0;

    always begin
        @(posedge clk);
        cyc++;
        #1;
        sbox_ready_i = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        randombits_i = {18'($urandom), 8'(cyc * 37 + 5)};
        ready_i      = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
        if (rsq.size() != 0 && rsq[0].due == cyc) begin
            sbox_valid_i = 1'b1;
            sbox_a_i     = rsq[0].a;
            sbox_b_i     = rsq[0].b;
            void'(rsq.pop_front());
        end else begin
            sbox_valid_i = 1'b0;
            sbox_a_i     = '0;
            sbox_b_i     = '0;
        end
    end

    always begin
        @(negedge clk);
        if (rst_i) begin
            rsq.delete();
        end else if (sbox_valid_o && sbox_ready_i) begin
            logic [7:0] x, s, r;
            x = sbox_a_o ^ sbox_b_o;
            s = sbox_dec_o ? isb_t[x] : sb_t[x];
            r = 8'($urandom);
            rsq.push_back('{due: cyc + L, a: s ^ r, b: r});
            hs_cnt++;
            masks.push_back(sbox_b_o);
        end
        if (!rst_i && valid_o && ready_i) begin
            if (sbq.size() == 0) chk("unexpected_valid", 64'(valid_o), 64'h0);
            else begin
                chk("result", 64'(result_o), 64'(sbq[0].res));
                chk("id", 64'(instr_id_o), 64'(sbq[0].id));
                void'(sbq.pop_front());
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [1:0] bs, input logic [XW-1:0] id, input logic [31:0] exp);
        int n;
        valid_i = 1'b1; op_i = op; rs1_i = rs1; rs2_i = rs2; bs_i = bs; instr_id_i = id;
        n = 0;
        forever begin
            @(negedge clk);
            if (ready_o || n >= 200) break;
            n++;
            @(posedge clk); #1;
        end
        if (!ready_o) chk("accept_timeout", 64'(ready_o), 64'h1);
        @(posedge clk); #1;
        valid_i = 1'b0;
        if (n < 200) sbq.push_back('{res: exp, id: id});
    endtask

    task automatic wait_drain(input int bound);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(sbq.size()), 64'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, h0, m0;
        bit distinct;
        logic [31:0] sw_exp;
        int sw_hs;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 0;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb_t[x] = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isb_t[sb_t[x]] = 8'(x);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(ready_o), 64'h1);
        chk("rst_valid", 64'(valid_o), 64'h0);
        chk("rst_result", 64'(result_o), 64'h0);
        chk("rst_id", 64'(instr_id_o), 64'h0);
        chk("rst_sbox_valid", 64'(sbox_valid_o), 64'h0);
        chk("rst_sbox_data", 64'({sbox_a_o, sbox_b_o, sbox_rand_o, sbox_dec_o}), 64'h0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(posedge clk); #1;

        // Single-byte encs latency: valid_o 2+L cycles after accept.
        issue(3'b000, 32'h0, 32'h0, 2'd0, 4'h1, 32'h00000063);
        n = 0;
        do begin @(negedge clk); n++; end while (!valid_o && n < 50);
        chk("t1_latency", 64'(n), 64'(2 + L));
        wait_drain(100);

        issue(3'b001, 32'h0, 32'h0, 2'd0, 4'h2, 32'hA56363C6);
        issue(3'b001, 32'h0, 32'h0, 2'd1, 4'h3, 32'h6363C6A5);
        issue(3'b010, 32'h11111111, 32'h00000063, 2'd0, 4'h4, 32'h11111111);
        issue(3'b000, 32'h0, 32'h00000001, 2'd0, 4'h5, 32'h0000007C);
        issue(3'b011, 32'h0, 32'h0000007C, 2'd0, 4'h6, 32'h0B0D090E);
        issue(3'b101, 32'hDEADBEEF, 32'h12345678, 2'd2, 4'h7, 32'hDEADBEEF);
        wait_drain(200);

`ifdef CV32E40X_AES_SUBWORD_EN
        sw_exp = 32'h637C777B; sw_hs = 4;
`else
        sw_exp = 32'h0; sw_hs = 0;
`endif
        h0 = hs_cnt; m0 = masks.size();
        issue(3'b100, 32'h0, 32'h00010203, 2'd0, 4'h8, sw_exp);
        wait_drain(200);
        chk("t3_handshakes", 64'(hs_cnt - h0), 64'(sw_hs));
        distinct = 1'b1;
        for (int i = m0; i < masks.size(); i++)
            for (int j = i + 1; j < masks.size(); j++)
                if (masks[i] == masks[j]) distinct = 1'b0;
        chk("t3_masks_distinct", 64'(distinct), 64'h1);

        // Backpressure: two results held while the consumer stalls.
        rdy_mode = 0;
        @(posedge clk); #1;
        issue(3'b000, 32'h0, 32'h00000001, 2'd0, 4'h3, 32'h0000007C);
        issue(3'b001, 32'h0, 32'h0, 2'd1, 4'h4, 32'h6363C6A5);
        n = 0;
        do begin @(negedge clk); n++; end while (!valid_o && n < 50);
        repeat (6) @(negedge clk);
        chk("t4_ready_low", 64'(ready_o), 64'h0);
        repeat (3) begin
            @(negedge clk);
            chk("t4_hold_valid", 64'(valid_o), 64'h1);
            chk("t4_hold_result", 64'(result_o), 64'h0000007C);
            chk("t4_hold_id", 64'(instr_id_o), 64'h3);
        end
        @(posedge clk); #1;
        rdy_mode = 1;
        wait_drain(100);
        @(negedge clk);
        chk("t4_ready_back", 64'(ready_o), 64'h1);
        @(posedge clk); #1;

        // Kill with two instructions in flight and sbox latency 4.
        L = 4;
        issue(3'b000, 32'h0, 32'h00000001, 2'd0, 4'h8, 32'h0000007C);
        issue(3'b000, 32'h0, 32'h00000002, 2'd0, 4'h9, 32'h00000077);
        kill_i = 1'b1;
        sbq.delete();
        @(posedge clk); #1;
        kill_i = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("t5_ready_low", 64'(ready_o), 64'h0);
            chk("t5_valid_low", 64'(valid_o), 64'h0);
        end
        @(negedge clk);
        chk("t5_ready_back", 64'(ready_o), 64'h1);
        chk("t5_valid_after", 64'(valid_o), 64'h0);
        @(posedge clk); #1;
        issue(3'b000, 32'h01010101, 32'h00530000, 2'd2, 4'hA, 32'h01EC0101);
        wait_drain(100);

        // Random stalls, randomness and consumer backpressure against the unmasked model.
        L = 2;
        stall_en = 1'b1;
        rdy_mode = 2;
        for (int i = 0; i < 1000; i++) begin
            logic [2:0]  op;
            logic [31:0] r1, r2;
            logic [1:0]  b;
            op = 3'($urandom_range(0, 7));
            r1 = $urandom;
            r2 = $urandom;
            b  = 2'($urandom_range(0, 3));
            issue(op, r1, r2, b, 4'(i), ref_result(op, r1, r2, b));
        end
        wait_drain(5000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
